// File: rtl/sram2axi_pkg.sv
// Shared types and constants for the SRAM-to-AXI4-Lite bridge.
package sram2axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    AW_W,
    B
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  // Grant index width, kept at least one bit so a single-port build still has a legal vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram2axi4_lite_arb_if.sv
// AXI4-Lite channel bundle between the bridge (master) and the interconnect (slave).
interface sram2axi4_lite_arb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                    ar_valid;
  logic                    ar_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [2:0]              ar_prot;

  logic                    aw_valid;
  logic                    aw_ready;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [2:0]              aw_prot;

  logic                    rd_valid;
  logic                    rd_ready;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic [1:0]              rd_resp;

  logic                    wd_valid;
  logic                    wd_ready;
  logic [DATA_WIDTH-1:0]   wd_data;
  logic [DATA_WIDTH/8-1:0] wstrb;

  logic                    wr_valid;
  logic                    wr_ready;
  logic [1:0]              wr_breap;

  modport master (
    output ar_valid, ar_addr, ar_prot, input ar_ready,
    output aw_valid, aw_addr, aw_prot, input aw_ready,
    input  rd_valid, rd_data, rd_resp, output rd_ready,
    output wd_valid, wd_data, wstrb, input wd_ready,
    input  wr_valid, wr_breap, output wr_ready
  );

  modport slave (
    input  ar_valid, ar_addr, ar_prot, output ar_ready,
    input  aw_valid, aw_addr, aw_prot, output aw_ready,
    output rd_valid, rd_data, rd_resp, input rd_ready,
    input  wd_valid, wd_data, wstrb, output wd_ready,
    output wr_valid, wr_breap, input wr_ready
  );

endinterface

// File: rtl/sram2axi_arbiter.sv
// Combinational requester grant. With SRAM2AXI_RR_ARB_EN defined it is round-robin
// from a pointer register; otherwise fixed priority with the lowest index winning.
module sram2axi_arbiter
  import sram2axi_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = 1
) (
  input  logic                 aclk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 take,
  output logic                 grant_valid,
  output logic [NUM_PORTS-1:0] grant_oh,
  output logic [IDX_W-1:0]     grant_idx
);

  logic [IDX_W-1:0] ptr;
  int               cand;

`ifdef SRAM2AXI_RR_ARB_EN
  // Pointer moves just past the port that was granted, so that port goes to the back of the queue.
  always_ff @(posedge aclk) begin
    if (!reset) begin
      ptr <= '0;
    end else if (take && grant_valid) begin
      ptr <= (int'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + IDX_W'(1);
    end
  end
`else
  logic unused_rr;
  assign ptr       = '0;
  assign unused_rr = ^{aclk, reset, take};
`endif

  always_comb begin
    grant_valid = 1'b0;
    grant_oh    = '0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_PORTS) begin
        cand = cand - NUM_PORTS;
      end
      if (!grant_valid && req[cand]) begin
        grant_valid    = 1'b1;
        grant_oh[cand] = 1'b1;
        grant_idx      = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/sram2axi4_lite_arb.sv
// Multi-port SRAM-to-AXI4-Lite bridge, one transaction in flight at a time.
// Define SRAM2AXI_RR_ARB_EN for round-robin arbitration (default: fixed priority).
module sram2axi4_lite_arb
  import sram2axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 2
) (
  input  logic                              aclk,
  input  logic                              reset,
  input  logic [NUM_PORTS-1:0]              ce,
  input  logic [NUM_PORTS-1:0]              we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] wmask,
  output logic [DATA_WIDTH-1:0]             rdata,
  output logic [NUM_PORTS-1:0]              rdata_valid,
  output logic [NUM_PORTS-1:0]              write_finish,
  output logic [NUM_PORTS-1:0]              resp_err,
  sram2axi4_lite_arb_if.master              axi
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = idx_width(NUM_PORTS);

  state_t                 state;
  logic [NUM_PORTS-1:0]   owner_oh;
  logic [ADDR_WIDTH-1:0]  cap_addr;
  logic [DATA_WIDTH-1:0]  cap_wdata;
  logic [STRB_W-1:0]      cap_wmask;
  logic                   ar_valid_q;
  logic                   aw_valid_q;
  logic                   wd_valid_q;
  logic                   rd_ready_q;
  logic                   wr_ready_q;
  logic                   aw_done;
  logic                   w_done;

  logic                   grant_valid;
  logic [NUM_PORTS-1:0]   grant_oh;
  logic [IDX_W-1:0]       grant_idx;
  logic                   aw_fin;
  logic                   w_fin;
  logic                   rd_hs;
  logic                   b_hs;

  sram2axi_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_arbiter (
    .aclk        (aclk),
    .reset       (reset),
    .req         (ce),
    .take        (state == IDLE),
    .grant_valid (grant_valid),
    .grant_oh    (grant_oh),
    .grant_idx   (grant_idx)
  );

  // AW and W finish independently; a handshake in the current cycle counts as done.
  assign aw_fin = aw_done | (aw_valid_q & axi.aw_ready);
  assign w_fin  = w_done  | (wd_valid_q & axi.wd_ready);
  assign rd_hs  = rd_ready_q & axi.rd_valid;
  assign b_hs   = wr_ready_q & axi.wr_valid;

  always_ff @(posedge aclk) begin
    if (!reset) begin
      state      <= IDLE;
      owner_oh   <= '0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_wmask  <= '0;
      ar_valid_q <= 1'b0;
      aw_valid_q <= 1'b0;
      wd_valid_q <= 1'b0;
      rd_ready_q <= 1'b0;
      wr_ready_q <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner_oh  <= grant_oh;
            cap_addr  <= addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            cap_wdata <= wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            cap_wmask <= wmask[int'(grant_idx)*STRB_W +: STRB_W];
            if (we[grant_idx]) begin
              state      <= AW_W;
              aw_valid_q <= 1'b1;
              wd_valid_q <= 1'b1;
              aw_done    <= 1'b0;
              w_done     <= 1'b0;
            end else begin
              state      <= AR;
              ar_valid_q <= 1'b1;
            end
          end
        end
        AR: begin
          if (axi.ar_ready) begin
            ar_valid_q <= 1'b0;
            rd_ready_q <= 1'b1;
            state      <= R;
          end
        end
        R: begin
          if (axi.rd_valid) begin
            rd_ready_q <= 1'b0;
            state      <= IDLE;
          end
        end
        AW_W: begin
          if (aw_valid_q && axi.aw_ready) begin
            aw_valid_q <= 1'b0;
            aw_done    <= 1'b1;
          end
          if (wd_valid_q && axi.wd_ready) begin
            wd_valid_q <= 1'b0;
            w_done     <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            wr_ready_q <= 1'b1;
            state      <= B;
          end
        end
        B: begin
          if (axi.wr_valid) begin
            wr_ready_q <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign axi.ar_valid = ar_valid_q;
  assign axi.ar_addr  = cap_addr;
  assign axi.ar_prot  = AXI_PROT_DEFAULT;
  assign axi.aw_valid = aw_valid_q;
  assign axi.aw_addr  = cap_addr;
  assign axi.aw_prot  = AXI_PROT_DEFAULT;
  assign axi.wd_valid = wd_valid_q;
  assign axi.wd_data  = cap_wdata;
  assign axi.wstrb    = cap_wmask;
  assign axi.rd_ready = rd_ready_q;
  assign axi.wr_ready = wr_ready_q;

  // Completion goes to the owner only, in the same cycle as the R/B handshake.
  assign rdata        = axi.rd_data;
  assign rdata_valid  = rd_hs ? owner_oh : '0;
  assign write_finish = b_hs ? owner_oh : '0;
  assign resp_err     = ((rd_hs && (axi.rd_resp != AXI_RESP_OKAY)) ||
                         (b_hs && (axi.wr_breap != AXI_RESP_OKAY))) ? owner_oh : '0;

endmodule
